// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared types and helpers for the FIFO write-port arbiter
//
// Contents:
//   arb_state_t : two-state arbiter FSM encoding (ARB_IDLE / ARB_BURST)
//   clog2       : constant-foldable ceil(log2(value)), used to size the beat counter

package fifo_write_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester/FIFO handshake bundle for the write-port arbiter
//
// Signals:
//   req        requester -> arb   per-requester request, held while data is pending
//   req_last   requester -> arb   current word is the last of that requester's burst
//   req_data   requester -> arb   flattened words, requester i at [i*word_width +: word_width]
//   stk_full   fifo      -> arb   FIFO full flag
//   accept     arb -> requester   one-hot, word of requester i written this cycle
//   gnt        arb -> requester   one-hot registered owner, 0 when idle
//   owner_idx  arb -> requester   current / last owner index
//   busy       arb -> requester   arbiter is in a burst
//   data_in    arb -> fifo        write data (0 when not writing)
//   write      arb -> fifo        write strobe
// Modports: master = arbiter side, slave = requester/FIFO environment side.

interface fifo_write_arbiter_if #(
    parameter int word_width    = 32,
    parameter int num_req       = 4,
    parameter int req_idx_width = 2
);

    logic [num_req-1:0]            req;
    logic [num_req-1:0]            req_last;
    logic [num_req*word_width-1:0] req_data;
    logic                          stk_full;
    logic [num_req-1:0]            accept;
    logic [num_req-1:0]            gnt;
    logic [req_idx_width-1:0]      owner_idx;
    logic                          busy;
    logic [word_width-1:0]         data_in;
    logic                          write;

    modport master (
        input  req, req_last, req_data, stk_full,
        output accept, gnt, owner_idx, busy, data_in, write
    );

    modport slave (
        output req, req_last, req_data, stk_full,
        input  accept, gnt, owner_idx, busy, data_in, write
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin requester picker
//
// Ports:
//   req          in   num_req         request vector
//   last_idx     in   req_idx_width   index of the previous owner; scan starts at last_idx+1
//   pick_onehot  out  num_req         one-hot winner (0 when nothing requested)
//   pick_idx     out  req_idx_width   index of the winner (0 when nothing requested)
//   pick_valid   out  1               at least one request was found

module fifo_write_arbiter_rr_pick #(
    parameter int num_req       = 4,
    parameter int req_idx_width = 2
) (
    input  logic [num_req-1:0]       req,
    input  logic [req_idx_width-1:0] last_idx,
    output logic [num_req-1:0]       pick_onehot,
    output logic [req_idx_width-1:0] pick_idx,
    output logic                     pick_valid
);

    // Scan last_idx+1, last_idx+2, ... wrapping; the previous owner is visited
    // last, so it only wins again when nobody else is asking.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        for (int k = 1; k <= num_req; k++) begin
            int                       cand;
            logic [req_idx_width-1:0] cand_idx;
            cand     = (int'(last_idx) + k) % num_req;
            cand_idx = req_idx_width'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid            = 1'b1;
                pick_idx              = cand_idx;
                pick_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-owning arbiter for the FIFO write port
//
// Ports:
//   clk   in   1   FIFO write clock
//   rst   in   1   synchronous active-high reset
//   bus   fifo_write_arbiter_if.master
//         req/req_last/req_data/stk_full in; accept/gnt/owner_idx/busy/data_in/write out
//
// A requester granted in IDLE owns the port in BURST until it flags req_last on a
// written word, writes max_burst words, or drops req. stk_full stalls the burst
// without ending it. IDLE always costs one cycle between owners.

module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int word_width    = 32,
    parameter int num_req       = 4,
    parameter int req_idx_width = 2,
    parameter int max_burst     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_arbiter_if.master bus
);

    localparam int beat_width = clog2(max_burst) + 1;
    localparam logic [beat_width-1:0] beat_final = beat_width'(max_burst - 1);

    arb_state_t               state_q;
    arb_state_t               state_d;
    logic [req_idx_width-1:0] owner_q;
    logic [req_idx_width-1:0] owner_d;
    logic [num_req-1:0]       gnt_q;
    logic [num_req-1:0]       gnt_d;
    logic [beat_width-1:0]    beat_q;
    logic [beat_width-1:0]    beat_d;

    logic [num_req-1:0]       pick_onehot;
    logic [req_idx_width-1:0] pick_idx;
    logic                     pick_valid;

    logic [word_width-1:0]    words [num_req];
    logic                     owner_req;
    logic                     owner_last;
    logic                     write_en;

    fifo_write_arbiter_rr_pick #(
        .num_req       (num_req),
        .req_idx_width (req_idx_width)
    ) u_rr_pick (
        .req         (bus.req),
        .last_idx    (owner_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    for (genvar g = 0; g < num_req; g++) begin : g_unflatten
        assign words[g] = bus.req_data[g*word_width +: word_width];
    end

    // Only the owner's signals matter; everything else on the bus is ignored.
    // rst gates the strobe so a reset landing mid-burst never writes.
    always_comb begin
        owner_req  = bus.req[owner_q];
        owner_last = bus.req_last[owner_q];
        write_en   = (state_q == ARB_BURST) && owner_req && !bus.stk_full && !rst;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BURST;
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    beat_d  = '0;
                end
            end
            ARB_BURST: begin
                if (!owner_req) begin
                    // Abandoned burst: no write this cycle, owner_idx is kept so
                    // the next scan starts after this requester.
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    beat_d  = '0;
                end else if (write_en) begin
                    // req_last and the max_burst boundary may coincide; both
                    // collapse into the same single exit.
                    if (owner_last || (beat_q == beat_final)) begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + beat_width'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                beat_d  = '0;
            end
        endcase
    end

    // owner resets to num_req-1 so the first scan starts at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= req_idx_width'(num_req - 1);
            gnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        bus.accept = '0;
        bus.data_in = '0;
        if (write_en) begin
            bus.accept[owner_q] = 1'b1;
            bus.data_in         = words[owner_q];
        end
    end

    assign bus.write     = write_en;
    assign bus.gnt       = gnt_q;
    assign bus.owner_idx = owner_q;
    assign bus.busy      = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter

module tb_fifo_write_arbiter;

    localparam int word_width    = 32;
    localparam int num_req       = 4;
    localparam int req_idx_width = 2;
    localparam int max_burst     = 8;

    typedef struct packed {
        logic                  last;
        logic [word_width-1:0] data;
    } word_t;

    typedef struct packed {
        logic [num_req-1:0]       gnt;
        logic                     wr;
        logic                     chk_owner;
        logic [req_idx_width-1:0] owner;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(
        .word_width    (word_width),
        .num_req       (num_req),
        .req_idx_width (req_idx_width)
    ) bus ();

    fifo_write_arbiter #(
        .word_width    (word_width),
        .num_req       (num_req),
        .req_idx_width (req_idx_width),
        .max_burst     (max_burst)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word_t                 src_q [num_req][$];
    logic [word_width-1:0] exp_q [num_req][$];
    cyc_t                  exp_cyc_q [$];
    logic [num_req-1:0]    en;
    logic [num_req-1:0]    pop_pend;
    int                    n_checks;
    int                    n_errors;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic load(input int r, input int n, input int last_at, input int tag);
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.data = {8'(r), 8'(tag), 16'(k)};
            w.last = (k + 1 == last_at);
            src_q[r].push_back(w);
            exp_q[r].push_back(w.data);
        end
    endtask

    task automatic push_cyc(input logic [num_req-1:0] g, input logic wr, input int n,
                            input logic chk_owner, input logic [req_idx_width-1:0] owner);
        cyc_t c;
        c.gnt = g;
        c.wr = wr;
        c.chk_owner = chk_owner;
        c.owner = owner;
        for (int k = 0; k < n; k++) exp_cyc_q.push_back(c);
    endtask

    task automatic drive();
        logic [num_req-1:0]            r;
        logic [num_req-1:0]            l;
        logic [num_req*word_width-1:0] d;
        r = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < num_req; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                r[i] = 1'b1;
                l[i] = src_q[i][0].last;
                d[i*word_width +: word_width] = src_q[i][0].data;
            end
        end
        bus.req      = r;
        bus.req_last = l;
        bus.req_data = d;
    endtask

    task automatic monitor();
        cyc_t c;
        check("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
        check("accept_onehot0", 64'($onehot0(bus.accept)), 64'd1);
        check("write_vs_accept", 64'(bus.write), 64'(|bus.accept));
        if (bus.stk_full) check("write_while_full", 64'(bus.write), 64'd0);
        if (exp_cyc_q.size() > 0) begin
            c = exp_cyc_q.pop_front();
            check("gnt", 64'(bus.gnt), 64'(c.gnt));
            check("write", 64'(bus.write), 64'(c.wr));
            check("busy", 64'(bus.busy), 64'(|c.gnt));
            if (c.chk_owner) check("owner_idx", 64'(bus.owner_idx), 64'(c.owner));
        end
        if (bus.write) begin
            check("accept_is_gnt", 64'(bus.accept), 64'(bus.gnt));
            for (int i = 0; i < num_req; i++) begin
                if (bus.accept[i]) begin
                    check("exp_avail", 64'(exp_q[i].size() > 0), 64'd1);
                    if (exp_q[i].size() > 0)
                        check("data_in", 64'(bus.data_in), 64'(exp_q[i].pop_front()));
                    pop_pend[i] = 1'b1;
                end
            end
        end else begin
            check("data_idle", 64'(bus.data_in), 64'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < num_req; i++)
            if (pop_pend[i]) void'(src_q[i].pop_front());
        pop_pend = '0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < num_req; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        exp_cyc_q.delete();
        en = '1;
        bus.stk_full = 1'b0;
        drive();
        tick();
        rst = 1'b0;
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_cyc_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", 64'(exp_cyc_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        pop_pend = '0;

        // Reset with all requesting, then full round robin 0,1,2,3,0 of max_burst words
        rst = 1'b1;
        bus.stk_full = 1'b0;
        en = '1;
        load(0, 16, 0, 1);
        for (int r = 1; r < num_req; r++) load(r, 8, 0, 1);
        drive();
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        for (int s = 0; s < 5; s++) begin
            push_cyc(4'(1 << (s % num_req)), 1'b1, max_burst, 1'b0, 2'd0);
            push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'(s % num_req));
        end
        tick();
        rst = 1'b0;
        drive();
        drain();

        // req0 burst of 3 ended by req_last, req2 pending
        do_reset();
        load(0, 3, 3, 3);
        load(2, 4, 4, 3);
        drive();
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b0001, 1'b1, 3, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd0);
        push_cyc(4'b0100, 1'b1, 4, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd2);
        drain();

        // stk_full stall of 5 cycles after 2 words; burst still totals max_burst
        do_reset();
        load(1, 16, 0, 4);
        drive();
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b0010, 1'b1, 2, 1'b0, 2'd0);
        push_cyc(4'b0010, 1'b0, 5, 1'b1, 2'd1);
        push_cyc(4'b0010, 1'b1, 6, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd1);
        push_cyc(4'b0010, 1'b1, 1, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) tick();
        bus.stk_full = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.stk_full = 1'b0;
        drain();

        // owner drops req after one word; RR continues at owner+1
        do_reset();
        load(0, 8, 0, 5);
        load(1, 4, 4, 5);
        load(3, 4, 4, 5);
        drive();
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b0001, 1'b1, 1, 1'b0, 2'd0);
        push_cyc(4'b0001, 1'b0, 1, 1'b1, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd0);
        push_cyc(4'b0010, 1'b1, 4, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd1);
        push_cyc(4'b1000, 1'b1, 4, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        for (int k = 0; k < 2; k++) tick();
        en[0] = 1'b0;
        drive();
        drain();

        // reset asserted mid-burst
        do_reset();
        load(2, 8, 0, 6);
        drive();
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b0100, 1'b1, 2, 1'b0, 2'd0);
        push_cyc(4'b0100, 1'b0, 1, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b0100, 1'b1, 6, 1'b0, 2'd0);
        push_cyc(4'b0100, 1'b0, 1, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd2);
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        drive();
        drain();

        // req_last coinciding with the max_burst boundary: one exit only
        do_reset();
        load(3, 16, max_burst, 7);
        drive();
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b1000, 1'b1, max_burst, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        push_cyc(4'b1000, 1'b1, max_burst, 1'b0, 2'd0);
        push_cyc(4'b0000, 1'b0, 1, 1'b1, 2'd3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
